// File: rtl/pattern_model_generator.sv
// Siteswap pattern model generator: schedules throws through an 8-entry beat-slot ring and
// evaluates each ball's parabolic arc once per video frame, presenting an atomic snapshot.
module pattern_model_generator #(
    parameter int unsigned BEAT_FRAMES = 8,
    parameter int unsigned RIGHT_X     = 960,
    parameter int unsigned LEFT_X      = 320,
    parameter int unsigned HAND_Y      = 600,
    parameter int unsigned ARC_GAIN    = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [2:0]  pattern_digits_in [7],
    input  logic [2:0]  pattern_len_in,
    input  logic [2:0]  num_balls_in,
    input  logic        frame_tick_in,
    output logic [2:0]  num_balls,
    output logic [10:0] model_balls_x [7],
    output logic [9:0]  model_balls_y [7],
    output logic        data_valid_out,
    output logic        busy_out,
    output logic        config_error,
    output logic        collision_error
);

    typedef enum logic [2:0] {
        StUnconfigured, StIdle, StThrow, StBallSetup, StDivide, StBallWrite, StPresent
    } state_e;

    state_e      r_state;
    logic [2:0]  r_digits [8];
    logic [2:0]  r_len, r_num, r_k, r_b;
    logic [4:0]  r_f;
    logic [2:0]  r_slot_ball [8];
    logic [7:0]  r_slot_vld;
    logic [7:0]  r_t [8];
    logic [7:0]  r_dur [8];
    logic [10:0] r_from [8];
    logic [10:0] r_to [8];
    logic [10:0] r_stage_x [8];
    logic [9:0]  r_stage_y [8];
    logic [10:0] r_out_x [7];
    logic [9:0]  r_out_y [7];
    logic [19:0] r_dvd;
    logic [10:0] r_quot;
    logic [7:0]  r_rem;
    logic [4:0]  r_cnt;
    logic        r_neg, r_valid, r_busy, r_cfg_err, r_col_err;

    function automatic logic [10:0] hand(input logic [2:0] beat);
        return beat[0] ? 11'(LEFT_X) : 11'(RIGHT_X);
    endfunction

    // Configuration check: sum of the valid digits must equal balls * length.
    logic [5:0] w_digit_sum, w_expect_sum;
    logic       w_cfg_ok;
    always_comb begin
        w_digit_sum = '0;
        for (int i = 0; i < 7; i++) begin
            if (3'(i) < pattern_len_in) w_digit_sum = w_digit_sum + 6'(pattern_digits_in[i]);
        end
    end
    assign w_expect_sum = 6'(num_balls_in) * 6'(pattern_len_in);
    assign w_cfg_ok = (w_digit_sum == w_expect_sum) && (pattern_len_in != 3'd0)
                      && (num_balls_in != 3'd0);

    // Throw decode for the current beat.
    logic [2:0] w_didx, w_d, w_land, w_throw_ball;
    assign w_didx       = (r_len != 3'd0) ? (r_k % r_len) : 3'd0;
    assign w_d          = r_digits[w_didx];
    assign w_land       = r_k + w_d;
    assign w_throw_ball = r_slot_ball[r_k];

    // Per-ball evaluation datapath for ball r_b.
    logic [7:0]         w_cur_t, w_cur_dur;
    logic [10:0]        w_cur_from, w_cur_to, w_quot_s, w_x;
    logic signed [11:0] w_dx;
    logic signed [19:0] w_dx_ext, w_prod;
    logic [19:0]        w_abs;
    logic [8:0]         w_trial;
    logic               w_ge;
    logic [31:0]        w_arc_full;
    logic [9:0]         w_arc, w_y;
    assign w_cur_t    = r_t[r_b];
    assign w_cur_dur  = r_dur[r_b];
    assign w_cur_from = r_from[r_b];
    assign w_cur_to   = r_to[r_b];
    assign w_dx       = $signed({1'b0, w_cur_to}) - $signed({1'b0, w_cur_from});
    assign w_dx_ext   = {{8{w_dx[11]}}, w_dx};
    assign w_prod     = w_dx_ext * $signed({12'd0, w_cur_t});
    assign w_abs      = w_prod[19] ? (~w_prod + 20'd1) : w_prod;
    assign w_trial    = {r_rem, r_dvd[19]};
    assign w_ge       = w_trial >= {1'b0, w_cur_dur};
    // |quotient| never exceeds |dx| because t <= T, so 11 bits hold it.
    assign w_quot_s   = r_neg ? (11'd0 - r_quot) : r_quot;
    assign w_x        = w_cur_from + w_quot_s;
    assign w_arc_full = (32'(w_cur_t) * 32'(w_cur_dur - w_cur_t) * ARC_GAIN) >> 4;
    assign w_arc      = (w_arc_full > HAND_Y) ? 10'(HAND_Y) : w_arc_full[9:0];
    assign w_y        = 10'(HAND_Y) - w_arc;

    // Control FSM, throw scheduler, serial divider and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= StUnconfigured;
            r_len      <= '0;
            r_num      <= '0;
            r_k        <= '0;
            r_b        <= '0;
            r_f        <= '0;
            r_slot_vld <= '0;
            r_dvd      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_col_err  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_digits[i]    <= '0;
                r_slot_ball[i] <= '0;
                r_t[i]         <= '0;
                r_dur[i]       <= '0;
                r_from[i]      <= '0;
                r_to[i]        <= '0;
                r_stage_x[i]   <= '0;
                r_stage_y[i]   <= '0;
            end
            for (int i = 0; i < 7; i++) begin
                r_out_x[i] <= '0;
                r_out_y[i] <= '0;
            end
        end else if (start_in) begin
            for (int i = 0; i < 7; i++) r_digits[i] <= pattern_digits_in[i];
            r_digits[7] <= '0;
            r_len       <= pattern_len_in;
            r_num       <= num_balls_in;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            if (w_cfg_ok) begin
                r_cfg_err  <= 1'b0;
                r_col_err  <= 1'b0;
                r_k        <= '0;
                r_f        <= '0;
                r_state    <= StIdle;
                for (int i = 0; i < 8; i++) begin
                    r_slot_ball[i] <= 3'(i);
                    r_slot_vld[i]  <= 3'(i) < num_balls_in;
                    r_t[i]         <= '0;
                    r_dur[i]       <= '0;
                    r_from[i]      <= hand(3'(i));
                    r_to[i]        <= hand(3'(i));
                end
            end else begin
                r_cfg_err <= 1'b1;
                r_state   <= StUnconfigured;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (frame_tick_in) begin
                        r_busy  <= 1'b1;
                        r_state <= StThrow;
                    end
                end
                StThrow: begin
                    if (r_f == 5'd0 && r_slot_vld[r_k]) begin
                        r_slot_vld[r_k] <= 1'b0;
                        if (w_d != 3'd0) begin
                            r_dur[w_throw_ball]  <= 8'(w_d * BEAT_FRAMES);
                            r_t[w_throw_ball]    <= '0;
                            r_from[w_throw_ball] <= hand(r_k);
                            r_to[w_throw_ball]   <= hand(w_land);
                            r_slot_ball[w_land]  <= w_throw_ball;
                            r_slot_vld[w_land]   <= 1'b1;
                            if (r_slot_vld[w_land]) r_col_err <= 1'b1;
                        end
                    end
                    r_b     <= '0;
                    r_state <= StBallSetup;
                end
                StBallSetup: begin
                    r_neg   <= w_prod[19];
                    r_dvd   <= w_abs;
                    r_quot  <= '0;
                    r_rem   <= '0;
                    r_cnt   <= 5'd19;
                    r_state <= (w_cur_dur == 8'd0) ? StBallWrite : StDivide;
                end
                StDivide: begin
                    r_rem  <= w_ge ? 8'(w_trial - {1'b0, w_cur_dur}) : w_trial[7:0];
                    r_quot <= {r_quot[9:0], w_ge};
                    r_dvd  <= {r_dvd[18:0], 1'b0};
                    r_cnt  <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) r_state <= StBallWrite;
                end
                StBallWrite: begin
                    r_stage_x[r_b] <= w_x;
                    r_stage_y[r_b] <= w_y;
                    if (w_cur_t < w_cur_dur) r_t[r_b] <= w_cur_t + 8'd1;
                    if (r_b == r_num - 3'd1) begin
                        r_state <= StPresent;
                    end else begin
                        r_b     <= r_b + 3'd1;
                        r_state <= StBallSetup;
                    end
                end
                StPresent: begin
                    for (int i = 0; i < 7; i++) begin
                        r_out_x[i] <= (3'(i) < r_num) ? r_stage_x[i] : 11'd0;
                        r_out_y[i] <= (3'(i) < r_num) ? r_stage_y[i] : 10'd0;
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    if (r_f == 5'(BEAT_FRAMES - 1)) begin
                        r_f <= '0;
                        r_k <= r_k + 3'd1;
                    end else begin
                        r_f <= r_f + 5'd1;
                    end
                    r_state <= StIdle;
                end
                default: ;
            endcase
        end
    end

    assign num_balls       = r_num;
    assign data_valid_out  = r_valid;
    assign busy_out        = r_busy;
    assign config_error    = r_cfg_err;
    assign collision_error = r_col_err;
    for (genvar g = 0; g < 7; g++) begin : g_out
        assign model_balls_x[g] = r_out_x[g];
        assign model_balls_y[g] = r_out_y[g];
    end

endmodule

// File: tb/tb_pattern_model_generator.sv
// Scoreboard bench for pattern_model_generator: expected snapshots are queued per tick and
// popped by a monitor on every data_valid_out pulse.
module tb_pattern_model_generator;

    typedef struct packed {
        logic            chk;
        logic [2:0]      nb;
        logic [6:0][10:0] x;
        logic [6:0][9:0]  y;
    } exp_t;

    logic        clk, rst, start, tick;
    logic [2:0]  digits [7];
    logic [2:0]  len, num;
    logic [2:0]  nb_o;
    logic [10:0] mx [7];
    logic [9:0]  my [7];
    logic        valid_o, busy_o, cfg_err_o, col_err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q [$];
    exp_t mon_e;
    exp_t any_e;

    pattern_model_generator dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .start_in          (start),
        .pattern_digits_in (digits),
        .pattern_len_in    (len),
        .num_balls_in      (num),
        .frame_tick_in     (tick),
        .num_balls         (nb_o),
        .model_balls_x     (mx),
        .model_balls_y     (my),
        .data_valid_out    (valid_o),
        .busy_out          (busy_o),
        .config_error      (cfg_err_o),
        .collision_error   (col_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic chk, input logic [2:0] nb, input int x0, input int y0,
                                input int x1, input int y1, input int x2, input int y2);
        exp_t e;
        e     = '0;
        e.chk = chk;
        e.nb  = nb;
        e.x[0] = 11'(x0); e.y[0] = 10'(y0);
        e.x[1] = 11'(x1); e.y[1] = 10'(y1);
        e.x[2] = 11'(x2); e.y[2] = 10'(y2);
        return e;
    endfunction

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk) begin
                    check("num_balls", int'(nb_o), int'(mon_e.nb));
                    for (int i = 0; i < 7; i++) begin
                        check($sformatf("ball%0d_x", i), int'(mx[i]), int'(mon_e.x[i]));
                        check($sformatf("ball%0d_y", i), int'(my[i]), int'(mon_e.y[i]));
                    end
                end
            end
        end
    end

    task automatic pulse_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    // Issue a tick; with want_pulse the expectation is queued and the drain is bounded.
    task automatic do_tick(input exp_t e, input bit want_pulse);
        int n;
        n = 0;
        if (want_pulse) sb_q.push_back(e);
        pulse_tick();
        if (want_pulse) begin
            while (sb_q.size() != 0 && n < 400) begin
                @(posedge clk); #1;
                n++;
            end
            if (sb_q.size() != 0) begin
                check("pulse_timeout", 0, 1);
                sb_q.delete();
            end
        end else begin
            repeat (250) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int d0, input int d1, input int d2, input int l, input int n);
        for (int i = 0; i < 7; i++) digits[i] = 3'd0;
        digits[0] = 3'(d0);
        digits[1] = 3'(d1);
        digits[2] = 3'(d2);
        len   = 3'(l);
        num   = 3'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(valid_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_cfg_err"}, int'(cfg_err_o), 0);
        check({tag, "_col_err"}, int'(col_err_o), 0);
        check({tag, "_num"}, int'(nb_o), 0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_x%0d", tag, i), int'(mx[i]), 0);
            check($sformatf("%s_y%0d", tag, i), int'(my[i]), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        any_e = mk(1'b0, 3'd0, 0, 0, 0, 0, 0, 0);
        rst   = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        len   = 3'd0;
        num   = 3'd0;
        for (int i = 0; i < 7; i++) digits[i] = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");
        do_tick(any_e, 1'b0);  // unconfigured: ignored

        // Cascade "3" with three balls.
        do_start(3, 0, 0, 1, 3);
        check("cascade_cfg_err", int'(cfg_err_o), 0);
        for (int i = 0; i < 25; i++) begin
            if (i == 0)       do_tick(mk(1'b1, 3'd3, 960, 600, 320, 600, 960, 600), 1'b1);
            else if (i == 12) do_tick(mk(1'b1, 3'd3, 640, 528, 426, 560, 960, 600), 1'b1);
            else if (i == 24) do_tick(mk(1'b1, 3'd3, 320, 600, 746, 536, 747, 536), 1'b1);
            else              do_tick(any_e, 1'b1);
        end

        // Digits {3,4}: sum 7 against 6 is rejected.
        do_start(3, 4, 0, 2, 3);
        check("bad_cfg_err", int'(cfg_err_o), 1);
        do_tick(any_e, 1'b0);
        check("bad_cfg_busy", int'(busy_o), 0);

        // Digits {4,3,2}: balls 0 and 1 both land on beat 4.
        do_start(4, 3, 2, 3, 3);
        check("coll_cfg_err", int'(cfg_err_o), 0);
        check("coll_initial", int'(col_err_o), 0);
        do_tick(mk(1'b1, 3'd3, 960, 600, 320, 600, 960, 600), 1'b1);
        for (int i = 1; i < 8; i++) do_tick(any_e, 1'b1);
        check("coll_before_beat1", int'(col_err_o), 0);
        do_tick(mk(1'b1, 3'd3, 960, 504, 320, 600, 960, 600), 1'b1);
        check("coll_at_beat1", int'(col_err_o), 1);
        do_tick(any_e, 1'b1);
        check("coll_sticky", int'(col_err_o), 1);

        // A second tick while busy is dropped: one pulse, frame counter advances once.
        do_start(3, 0, 0, 1, 3);
        check("cascade2_col_err", int'(col_err_o), 0);
        sb_q.push_back(mk(1'b1, 3'd3, 960, 600, 320, 600, 960, 600));
        pulse_tick();
        @(posedge clk); #1;
        pulse_tick();
        repeat (300) @(posedge clk);
        #1;
        check("double_tick_drained", sb_q.size(), 0);
        sb_q.delete();
        do_tick(mk(1'b1, 3'd3, 934, 589, 320, 600, 960, 600), 1'b1);

        // Reset in the middle of a frame: no pulse, everything cleared, ticks ignored.
        pulse_tick();
        repeat (5) @(posedge clk);
        #1;
        check("midframe_busy", int'(busy_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midreset");
        do_tick(any_e, 1'b0);
        check("post_reset_busy", int'(busy_o), 0);

        // "501" with two balls: the zero at beat 1 leaves ball 1 resting.
        do_start(5, 0, 1, 3, 2);
        check("p501_cfg_err", int'(cfg_err_o), 0);
        do_tick(mk(1'b1, 3'd2, 960, 600, 320, 600, 0, 0), 1'b1);
        for (int i = 1; i < 8; i++) do_tick(any_e, 1'b1);
        do_tick(mk(1'b1, 3'd2, 832, 472, 320, 600, 0, 0), 1'b1);

        repeat (20) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_model_generator.md
Name: pattern_model_generator

Overview:
- Produces the model ball trajectories for a configured siteswap pattern, one snapshot per video frame.
- Feeds the model side (model_balls_x/y, num_balls, data valid) of the pattern evaluation block.
- Schedules throws through a beat-slot ring and evaluates parabolic arcs per ball.
- Uses a shared serial divider for horizontal interpolation.

Parameters:
- BEAT_FRAMES, 8: frames per beat; range 1..32.
- RIGHT_X, 960: right-hand x coordinate, 11 bits.
- LEFT_X, 320: left-hand x coordinate, 11 bits.
- HAND_Y, 600: hand y coordinate, 10 bits.
- ARC_GAIN, 8: arc height gain.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse; latches configuration
- pattern_digits_in[6:0]  input  3 each  siteswap digits; index 0 is thrown first
- pattern_len_in  input  3  number of valid digits, 1..7
- num_balls_in  input  3  ball count, 1..7
- frame_tick_in  input  1  one-cycle pulse per video frame
- num_balls  output  3  latched ball count
- model_balls_x[6:0]  output  11 each  model x per ball
- model_balls_y[6:0]  output  10 each  model y per ball
- data_valid_out  output  1  one-cycle pulse when a new snapshot is presented
- busy_out  output  1  high while a frame computation is in progress
- config_error  output  1  sticky; configuration rejected
- collision_error  output  1  sticky; two balls scheduled to land on the same beat

Behaviour:
- Reset clears all outputs, registers, slots and the configuration; FSM returns to UNCONFIGURED.
- Clock and reset: one clock (clk_in); reset (rst_in) is synchronous and active-high.
- Reset mid-computation aborts the frame. No data_valid_out is issued for it.
- FSM states: UNCONFIGURED, IDLE, THROW, BALL_SETUP, DIVIDE, BALL_WRITE, PRESENT.
- start_in, accepted in any state:
  - Latches digits, length and ball count.
  - Checks that the digit sum equals num_balls_in*pattern_len_in, and that both length and ball count are nonzero.
  - On failure: config_error=1 and the FSM goes to UNCONFIGURED.
  - On success: config_error=0, collision_error=0, beat k=0, frame-in-beat f=0, FSM goes to IDLE.
- Ball initialisation (on accepted configuration):
  - Ball b (b < num_balls) rests in hand(b) with t=T=0.
  - slot[b]=b, marked valid. All other slots are invalid.
- Hand assignment: hand(k) is the right hand (RIGHT_X) for even k and the left hand (LEFT_X) for odd k.
- Frame start: frame_tick_in in IDLE sets busy_out=1.
  - A tick outside IDLE is ignored: no queueing, no error.
  - A tick in UNCONFIGURED is ignored.
- THROW, executed only when f==0:
  - Digit d = digits[k mod len]; s = k mod 8.
  - If slot[s] is valid: let ball = slot[s] and clear the slot. If d>0:
    - Set ball.T=d*BEAT_FRAMES, ball.t=0, from=hand(k), to=hand(k+d).
    - Write slot[(k+d) mod 8]=ball. If that slot is already valid, collision_error=1 and the slot is overwritten.
  - d==0, or an empty slot: no action.
  - A write to slot s itself (d==8 is impossible) cannot occur.
- Per ball b < num_balls, sequentially in ascending order:
  - dx = to-from, signed 12 bits. Product P = dx*t, signed 20 bits.
  - Restoring divider: one quotient bit per cycle, 20 cycles, dividing |P| by T (8 bits).
  - Quotient truncates toward zero and its sign is restored from P.
  - x = from + quotient. When T==0, x=from and the divide is skipped.
  - arc = (t*(T-t)*ARC_GAIN)>>4, clamped to HAND_Y. y = HAND_Y - arc.
  - After the write, t increments, saturating at T. At t==T the ball sits at (to, HAND_Y).
- Outputs:
  - Results are staged internally and copied to model_balls_x/y atomically in PRESENT.
  - Entries b >= num_balls are driven to 0.
  - data_valid_out pulses for exactly one cycle in PRESENT; busy_out falls in the same cycle.
- Counters: f increments each frame; at BEAT_FRAMES-1 it wraps to 0 and k increments. k is 3 bits and wraps mod 8.
- Worst-case frame latency is at most 7*(20+3)+4 cycles.

Test Plan:
- Cascade "3", num 3, start, then tick #0 → pulse. Expected ball0=(960,600), ball1=(320,600), ball2=(960,600); balls 3..6 = (0,0).
- Continue to tick #12 → ball0 x=960+(-640*12)/24=640, y=600-72=528.
- Cascade, tick #24 → ball0 at (320,600); ball1 thrown at beat 1 shows t=16, x=320+640*16/24=746, y=600-64=536.
- Digits {3,4}, len 2, num 3 (sum 7 ≠ 6) → config_error=1; subsequent ticks give no data_valid_out.
- Digits {4,3,2}, num 3 (sum passes) → collision_error=1 at beat 1, i.e. tick #8; pulses continue.
- Second tick 2 cycles after the first → exactly one pulse. Reset asserted mid-frame → no pulse; all outputs 0; ticks ignored until a new start.
- "501", num 2 → at beat 1, d=0 leaves the ball resting; positions are unchanged except the airborne ball.
